shift_rotate_engine: RTL and testbench

SHIFT_ROTATE_ENGINE -- requirements
Module: shift_rotate_engine

---
 rtl/shift_pkg.sv | 23 ++
 rtl/shift_step.sv | 34 +++
 rtl/shift_rotate_engine.sv | 125 ++++++++++++
 tb/tb_shift_rotate_engine.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared types for the shift/rotate engine.
//   shift_mode_t : operation select carried on the engine's 3-bit mode port
//   state_t      : engine FSM state
package shift_pkg;

    typedef enum logic [2:0] {
        RLC  = 3'd0,  // rotate left through carry
        RRC  = 3'd1,  // rotate right through carry
        RL   = 3'd2,  // rotate left, carry = bit rotated out
        RR   = 3'd3,  // rotate right, carry = bit rotated out
        SLL  = 3'd4,  // logical shift left
        SRL  = 3'd5,  // logical shift right
        SRA  = 3'd6,  // arithmetic shift right
        RSVD = 3'd7   // reserved: pass-through
    } shift_mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_step.sv
// Single 1-bit step of a shift/rotate operation (purely combinational).
// Ports:
//   mode   : operation select (shift_mode_t encoding)
//   r, c   : current value and carry
//   r_next : value after one step
//   c_next : carry after one step
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] r,
    input  logic             c,
    output logic [WIDTH-1:0] r_next,
    output logic             c_next
);

    always_comb begin
        r_next = r;
        c_next = c;
        case (shift_mode_t'(mode))
            RLC: begin r_next = {r[WIDTH-2:0], c};          c_next = r[WIDTH-1]; end
            RRC: begin r_next = {c, r[WIDTH-1:1]};          c_next = r[0];       end
            RL:  begin r_next = {r[WIDTH-2:0], r[WIDTH-1]}; c_next = r[WIDTH-1]; end
            RR:  begin r_next = {r[0], r[WIDTH-1:1]};       c_next = r[0];       end
            SLL: begin r_next = {r[WIDTH-2:0], 1'b0};       c_next = r[WIDTH-1]; end
            SRL: begin r_next = {1'b0, r[WIDTH-1:1]};       c_next = r[0];       end
            SRA: begin r_next = {r[WIDTH-1], r[WIDTH-1:1]}; c_next = r[0];       end
            default: ;
        endcase
    end

endmodule

// File: rtl/shift_rotate_engine.sv
// Multi-cycle shift/rotate engine: one bit step per clock in SHIFT state.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   start        : request, accepted in IDLE or DONE
//   abort        : cancels an operation in SHIFT (no done pulse)
//   mode         : shift_mode_t operation select
//   operand      : value to process, latched on accepted start
//   carry_in     : initial carry, latched on accepted start
//   count        : number of steps, clamped to MAX_COUNT at latch time
//   busy         : high whenever the FSM is not IDLE
//   done         : one-cycle pulse when result is valid
//   result       : final value, held until the next completion
//   carry_out    : final carry, held with result
//   zero_out     : result == 0, held with result
module shift_rotate_engine
    import shift_pkg::*;
#(
    parameter  int WIDTH     = 4,
    parameter  int MAX_COUNT = WIDTH,
    localparam int CW        = $clog2(MAX_COUNT + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] operand,
    input  logic             carry_in,
    input  logic [CW-1:0]    count,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero_out
);

    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_COUNT);

    state_t            state;
    shift_mode_t       mode_q;
    logic [WIDTH-1:0]  work_r;
    logic              work_c;
    logic [CW-1:0]     remaining;
    logic [CW-1:0]     count_clamped;
    logic [WIDTH-1:0]  step_r;
    logic              step_c;
    logic              pass_through;

    assign count_clamped = (count > MAX_CNT) ? MAX_CNT : count;
    // Reserved mode and zero count complete without entering SHIFT.
    assign pass_through  = (count_clamped == '0) || (shift_mode_t'(mode) == RSVD);

    shift_step #(.WIDTH(WIDTH)) u_step (
        .mode   (mode_q),
        .r      (work_r),
        .c      (work_c),
        .r_next (step_r),
        .c_next (step_c)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            mode_q    <= RLC;
            work_r    <= '0;
            work_c    <= 1'b0;
            remaining <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            zero_out  <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (pass_through) begin
                            state     <= DONE;
                            remaining <= '0;
                            done      <= 1'b1;
                            result    <= operand;
                            carry_out <= carry_in;
                            zero_out  <= (operand == '0);
                        end else begin
                            state     <= SHIFT;
                            mode_q    <= shift_mode_t'(mode);
                            work_r    <= operand;
                            work_c    <= carry_in;
                            remaining <= count_clamped;
                        end
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (abort) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        remaining <= '0;
                    end else begin
                        work_r    <= step_r;
                        work_c    <= step_c;
                        remaining <= remaining - CW'(1);
                        // Last step: publish the stepped value directly.
                        if (remaining == CW'(1)) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            result    <= step_r;
                            carry_out <= step_c;
                            zero_out  <= (step_r == '0);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_rotate_engine.sv
// Self-checking bench for shift_rotate_engine: directed table, hand-written
// multi-cycle sequences and randomized operations against a reference model.
module tb_shift_rotate_engine;

    localparam int W    = 4;
    localparam int MAXC = 6;
    localparam int CWB  = $clog2(MAXC + 1);

    logic           clk = 1'b0;
    logic           reset_n;
    logic           start = 1'b0;
    logic           abort = 1'b0;
    logic [2:0]     mode = '0;
    logic [W-1:0]   operand = '0;
    logic           carry_in = 1'b0;
    logic [CWB-1:0] count = '0;
    logic           busy, done, carry_out, zero_out;
    logic [W-1:0]   result;

    logic           start8 = 1'b0;
    logic [2:0]     mode8 = '0;
    logic [7:0]     operand8 = '0;
    logic           carry8 = 1'b0;
    logic [3:0]     count8 = '0;
    logic           busy8, done8, carry_out8, zero_out8;
    logic [7:0]     result8;

    shift_rotate_engine #(.WIDTH(W), .MAX_COUNT(MAXC)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .mode(mode), .operand(operand), .carry_in(carry_in), .count(count),
        .busy(busy), .done(done), .result(result),
        .carry_out(carry_out), .zero_out(zero_out)
    );

    shift_rotate_engine #(.WIDTH(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .start(start8), .abort(1'b0),
        .mode(mode8), .operand(operand8), .carry_in(carry8), .count(count8),
        .busy(busy8), .done(done8), .result(result8),
        .carry_out(carry_out8), .zero_out(zero_out8)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    function automatic int rotl(input int v, input int n, input int bits);
        return ((v << n) | (v >> (bits - n))) & ((1 << bits) - 1);
    endfunction

    // Whole-operation model: n steps expressed as ring rotations and shifts.
    function automatic void model(input int md, input int op, input int ci, input int cnt,
                                  output int r, output int co, output int lat);
        int n, ring, sop, mask;
        mask = (1 << W) - 1;
        n    = (cnt > MAXC) ? MAXC : cnt;
        r    = op;
        co   = ci;
        lat  = 1;
        if (md == 7 || n == 0) return;
        lat = 1 + n;
        sop = (op ^ (1 << (W - 1))) - (1 << (W - 1));
        case (md)
            0: begin ring = rotl((op << 1) | ci, n % (W + 1), W + 1);
                     r = ring >> 1; co = ring & 1; end
            1: begin ring = rotl((op << 1) | ci, (W + 1) - (n % (W + 1)), W + 1);
                     r = ring >> 1; co = ring & 1; end
            2: begin r = rotl(op, n % W, W); co = r & 1; end
            3: begin r = rotl(op, (W - (n % W)) % W, W); co = (r >> (W - 1)) & 1; end
            4: begin r = (op << n) & mask; co = ((op << (n - 1)) >> (W - 1)) & 1; end
            5: begin r = op >> n; co = (op >> (n - 1)) & 1; end
            default: begin r = (sop >>> n) & mask; co = (sop >>> (n - 1)) & 1; end
        endcase
    endfunction

    // Drives one request at the current negedge and follows it to completion.
    task automatic run_op(input string tag, input int md, input int op, input int ci,
                          input int cnt, input int er, input int ec, input int elat);
        int k;
        mode = md[2:0]; operand = op[W-1:0]; carry_in = ci[0]; count = cnt[CWB-1:0];
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 1;
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
        end
        check({tag, " latency"}, k, elat);
        check({tag, " result"}, result, er);
        check({tag, " carry"}, carry_out, ec);
        check({tag, " zero"}, zero_out, (er == 0) ? 1 : 0);
        check({tag, " busy"}, busy, 1);
        @(negedge clk);
        check({tag, " done once"}, done, 0);
    endtask

    typedef struct {
        int md; int op; int ci; int cnt; int er; int ec; int elat;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int r, co, lat, dones, first_k, second_k;

        tbl[0]  = '{0, 4'h8, 0, 1, 4'h0, 1, 2};  // RLC into carry
        tbl[1]  = '{1, 4'h1, 1, 1, 4'h8, 1, 2};  // RRC
        tbl[2]  = '{0, 4'h1, 0, 5, 4'h1, 0, 6};  // RLC full ring
        tbl[3]  = '{6, 4'h8, 0, 3, 4'hF, 0, 4};  // SRA sign fill
        tbl[4]  = '{3, 4'h5, 1, 0, 4'h5, 1, 1};  // count 0
        tbl[5]  = '{7, 4'hA, 0, 3, 4'hA, 0, 1};  // reserved mode
        tbl[6]  = '{6, 4'h9, 0, 7, 4'hF, 1, 7};  // count clamped to 6
        tbl[7]  = '{2, 4'h9, 0, 1, 4'h3, 1, 2};  // RL
        tbl[8]  = '{3, 4'h9, 0, 2, 4'h6, 0, 3};  // RR
        tbl[9]  = '{4, 4'h3, 1, 2, 4'hC, 0, 3};  // SLL
        tbl[10] = '{5, 4'hE, 0, 3, 4'h1, 1, 4};  // SRL
        tbl[11] = '{2, 4'h0, 0, 0, 4'h0, 0, 1};  // zero operand pass

        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset result", result, 0);
        check("reset carry", carry_out, 0);
        check("reset zero", zero_out, 1);
        check("reset zero w8", zero_out8, 1);

        // Request presented together with reset release.
        @(negedge clk);
        reset_n = 1'b1;
        run_op("post-reset", 0, 4'h8, 0, 1, 4'h0, 1, 2);

        foreach (tbl[i]) begin
            @(negedge clk);
            run_op($sformatf("table%0d", i), tbl[i].md, tbl[i].op, tbl[i].ci,
                   tbl[i].cnt, tbl[i].er, tbl[i].ec, tbl[i].elat);
        end

        // start while SHIFT: second request must be ignored.
        @(negedge clk);
        mode = 3'd2; operand = 4'h1; carry_in = 1'b0; count = 3'd3; start = 1'b1;
        dones = 0; first_k = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            start = (k == 1);
            if (k == 1) begin mode = 3'd4; operand = 4'hF; count = 3'd0; end
            if (done) begin dones++; if (first_k == 0) first_k = k; end
        end
        check("ignore-start dones", dones, 1);
        check("ignore-start latency", first_k, 4);
        check("ignore-start result", result, 4'h8);
        check("ignore-start carry", carry_out, 0);

        // abort during SHIFT: back to IDLE, outputs keep previous completion.
        @(negedge clk);
        mode = 3'd3; operand = 4'h5; carry_in = 1'b1; count = 3'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dones = int'(done);
        @(negedge clk);
        check("abort busy before", busy, 1);
        dones += int'(done);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort busy after", busy, 0);
        for (int k = 0; k < 4; k++) begin
            dones += int'(done);
            @(negedge clk);
        end
        check("abort no done", dones, 0);
        check("abort result held", result, 4'h8);
        check("abort carry held", carry_out, 0);
        check("abort zero held", zero_out, 0);

        // Back-to-back: second request accepted in the DONE cycle.
        @(negedge clk);
        mode = 3'd5; operand = 4'hC; carry_in = 1'b0; count = 3'd2; start = 1'b1;
        dones = 0; first_k = 0; second_k = 0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k <= 7) check($sformatf("b2b busy k%0d", k), busy, 1);
            if (done) begin
                dones++;
                if (first_k == 0) begin
                    first_k = k;
                    check("b2b first result", result, 4'h3);
                    check("b2b first carry", carry_out, 0);
                    mode = 3'd0; operand = 4'h6; carry_in = 1'b1; count = 3'd3; start = 1'b1;
                end else begin
                    second_k = k;
                    check("b2b second result", result, 4'h5);
                    check("b2b second carry", carry_out, 1);
                end
            end
        end
        check("b2b dones", dones, 2);
        check("b2b first latency", first_k, 3);
        check("b2b second latency", second_k, 7);

        // WIDTH=8 instance, RL.
        @(negedge clk);
        mode8 = 3'd2; operand8 = 8'h81; carry8 = 1'b0; count8 = 4'd1; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        first_k = 1;
        while (!done8 && first_k < 40) begin
            @(negedge clk);
            first_k++;
        end
        check("w8 latency", first_k, 2);
        check("w8 result", result8, 8'h03);
        check("w8 carry", carry_out8, 1);
        check("w8 zero", zero_out8, 0);
        check("w8 busy", busy8, 1);

        for (int i = 0; i < 150; i++) begin
            int md, op, ci, cnt;
            md  = $urandom_range(7, 0);
            op  = $urandom_range((1 << W) - 1, 0);
            ci  = $urandom_range(1, 0);
            cnt = $urandom_range(7, 0);
            model(md, op, ci, cnt, r, co, lat);
            @(negedge clk);
            run_op($sformatf("rand%0d m%0d op%0h c%0d n%0d", i, md, op, ci, cnt),
                   md, op, ci, cnt, r, co, lat);
        end

        // Reset asserted mid-operation takes effect without a clock edge.
        @(negedge clk);
        mode = 3'd4; operand = 4'h7; carry_in = 1'b1; count = 3'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("async reset busy", busy, 0);
        check("async reset done", done, 0);
        check("async reset result", result, 0);
        check("async reset carry", carry_out, 0);
        check("async reset zero", zero_out, 1);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("after reset idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
